// File: rtl/mmio_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmio_timer_pkg                                               |
// | Description : Shared definitions for the memory-mapped timer: register     |
// |               word addresses, CTRL bit positions, bus FSM encoding and a   |
// |               byte-enable expansion helper.                                |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mmio_timer_pkg;

  // Register word addresses inside the timer window
  localparam logic [7:0] TMR_CTRL     = 8'h00;
  localparam logic [7:0] TMR_LOAD     = 8'h01;
  localparam logic [7:0] TMR_COUNT    = 8'h02;
  localparam logic [7:0] TMR_STATUS   = 8'h03;
  localparam logic [7:0] TMR_PRESCALE = 8'h04;

  // CTRL bit indices
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_AR_BIT     = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_WIDTH      = 3;

  // Bus transaction FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_t;

  // Expand 4 byte enables into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] mask);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{mask[i]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmio_timer_if                                                |
// | Description : Request/valid data-memory-port bundle shared by the core's   |
// |               load/store unit (master) and the timer responder (slave).    |
// | Signals     : request, we_re, masking[3:0], address[7:0], w_data[31:0]     |
// |               (master -> slave); valid, r_data[31:0] (slave -> master).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mmio_timer_if;
  logic        request;
  logic        we_re;
  logic [3:0]  masking;
  logic [7:0]  address;
  logic [31:0] w_data;
  logic        valid;
  logic [31:0] r_data;

  modport master (
    output request, we_re, masking, address, w_data,
    input  valid, r_data
  );

  modport slave (
    input  request, we_re, masking, address, w_data,
    output valid, r_data
  );
endinterface
`default_nettype wire

// File: rtl/mmio_timer_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmio_timer_core                                              |
// | Description : Prescaler, COUNT/LOAD datapath and sticky expired flag.      |
// |               Register writes arrive as one-cycle per-register strobes     |
// |               with already byte-masked data plus the bit mask.             |
// | Ports       : clk, rst (async, active-low)                                 |
// |               wr_*_i      per-register write strobes                       |
// |               wr_data_i   write data, disabled bytes forced to 0           |
// |               wr_bmask_i  bit mask of enabled bytes                        |
// |               ctrl_o, load_o, count_o, expired_o, prescale_o  reg values   |
// |               irq_o       registered expired & irq_en                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mmio_timer_core
  import mmio_timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_ctrl_i,
  input  logic                  wr_load_i,
  input  logic                  wr_count_i,
  input  logic                  wr_status_i,
  input  logic                  wr_prescale_i,
  input  logic [31:0]           wr_data_i,
  input  logic [31:0]           wr_bmask_i,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [31:0]           load_o,
  output logic [31:0]           count_o,
  output logic                  expired_o,
  output logic [15:0]           prescale_o,
  output logic                  irq_o
);

  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           count_q, count_d;
  logic [15:0]           pre_q, pre_d;
  logic [15:0]           pcnt_q, pcnt_d;
  logic                  expired_q, expired_d;
  logic                  irq_q, irq_d;
  logic                  tick;
  logic                  hw_expire;

  always_comb begin
    tick      = ctrl_q[CTRL_EN_BIT] && (pcnt_q == pre_q);
    hw_expire = tick && (count_q == '0);

    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    pre_d     = pre_q;
    expired_d = expired_q;
    // pcnt only runs while enabled; a tick or a disabled timer parks it at 0
    pcnt_d    = (ctrl_q[CTRL_EN_BIT] && !tick) ? pcnt_q + 16'd1 : 16'd0;
    irq_d     = expired_q & ctrl_q[CTRL_IRQ_EN_BIT];

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else if (ctrl_q[CTRL_AR_BIT]) begin
        count_d = load_q;
      end else begin
        ctrl_d[CTRL_EN_BIT] = 1'b0;
      end
    end

    // Hardware set of expired beats a same-cycle write-1-to-clear
    if (hw_expire) begin
      expired_d = 1'b1;
    end else if (wr_status_i && wr_data_i[0]) begin
      expired_d = 1'b0;
    end

    // Bus writes are applied last so they override any tick update above;
    // unwritten bytes keep their pre-tick value.
    if (wr_ctrl_i) begin
      ctrl_d = (ctrl_q & ~wr_bmask_i[CTRL_WIDTH-1:0]) | wr_data_i[CTRL_WIDTH-1:0];
      if (!ctrl_d[CTRL_EN_BIT]) begin
        pcnt_d = 16'd0;
      end
    end
    if (wr_load_i) begin
      load_d = (load_q & ~wr_bmask_i) | wr_data_i;
    end
    if (wr_count_i) begin
      count_d = (count_q & ~wr_bmask_i) | wr_data_i;
    end
    if (wr_prescale_i) begin
      pre_d = (pre_q & ~wr_bmask_i[15:0]) | wr_data_i[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      pre_q     <= '0;
      pcnt_q    <= '0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      pcnt_q    <= pcnt_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
    end
  end

  assign ctrl_o     = ctrl_q;
  assign load_o     = load_q;
  assign count_o    = count_q;
  assign expired_o  = expired_q;
  assign prescale_o = pre_q;
  assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmio_timer                                                   |
// | Description : Memory-mapped down-counting timer responder. Runs the        |
// |               request/valid bus FSM with WAIT_STATES (0..7) extra cycles,  |
// |               the register read mux, and drives a level interrupt.         |
// | Ports       : clk   single clock                                           |
// |               rst   asynchronous, active-low reset                         |
// |               bus   mmio_timer_if slave (request/we_re/masking/address/    |
// |                     w_data in; valid/r_data out)                           |
// |               irq_o registered STATUS.expired & CTRL.irq_en                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  mmio_timer_if.slave bus,
  output logic        irq_o
);

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  bus_state_t            state_q, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic                  we_q;
  logic [7:0]            addr_q;
  logic [3:0]            mask_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [7:0]            rd_addr;
  logic [31:0]           rd_mux;
  logic                  commit;
  logic [31:0]           bmask;

  logic [CTRL_WIDTH-1:0] ctrl;
  logic [31:0]           load;
  logic [31:0]           count;
  logic                  expired;
  logic [15:0]           prescale;

  // Bus FSM next state
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.request) begin
          wcnt_d  = WAIT_LOAD;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 3'd0) begin
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the same edge that accepts the
  // request, so the read mux must look at the live address in IDLE.
  assign rd_addr = (state_q == ST_IDLE) ? bus.address : addr_q;

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      TMR_CTRL:     rd_mux = {{(32-CTRL_WIDTH){1'b0}}, ctrl};
      TMR_LOAD:     rd_mux = load;
      TMR_COUNT:    rd_mux = count;
      TMR_STATUS:   rd_mux = {31'd0, expired};
      TMR_PRESCALE: rd_mux = {16'd0, prescale};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == ST_IDLE && bus.request) begin
        we_q    <= bus.we_re;
        addr_q  <= bus.address;
        mask_q  <= bus.masking;
        wdata_q <= bus.w_data;
      end
      // Read data is a snapshot of the registers at the edge entering RESP
      if (state_d == ST_RESP && state_q != ST_RESP) begin
        rdata_q <= rd_mux;
      end
    end
  end

  assign bus.valid  = (state_q == ST_RESP);
  assign bus.r_data = rdata_q;

  // Writes commit on the edge leaving RESP; an all-zero mask is a no-op
  assign commit = (state_q == ST_RESP) && we_q && (mask_q != 4'd0);
  assign bmask  = byte_mask(mask_q);

  mmio_timer_core u_core (
    .clk           (clk),
    .rst           (rst),
    .wr_ctrl_i     (commit && (addr_q == TMR_CTRL)),
    .wr_load_i     (commit && (addr_q == TMR_LOAD)),
    .wr_count_i    (commit && (addr_q == TMR_COUNT)),
    .wr_status_i   (commit && (addr_q == TMR_STATUS)),
    .wr_prescale_i (commit && (addr_q == TMR_PRESCALE)),
    .wr_data_i     (wdata_q & bmask),
    .wr_bmask_i    (bmask),
    .ctrl_o        (ctrl),
    .load_o        (load),
    .count_o       (count),
    .expired_o     (expired),
    .prescale_o    (prescale),
    .irq_o         (irq_o)
  );

endmodule
`default_nettype wire

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped down-counting timer that sits on the data-memory port as a second responder beside data memory. It speaks the same request/valid protocol as `memory_top`, with a configurable number of wait states. It drives a level interrupt to the core. The core's address decode routes `request` here for the timer window and selects this block's `valid`/`r_data`.

## Interface
- `WAIT_STATES`, default 1: extra cycles between accepting a request and asserting `valid`; legal range 0–7.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `request` input 1: transaction request; the requester holds it and all qualifiers stable until `valid`.
- `we_re` input 1: 1 = write, 0 = read.
- `masking` input 4: byte enables for writes; bit n enables `w_data[8n+7:8n]`; ignored on reads.
- `address` input 8: word address within the timer window.
- `w_data` input 32: write data.
- `valid` output 1: one-cycle completion pulse.
- `r_data` output 32: read data; meaningful only while `valid`=1.
- `irq` output 1: `STATUS.expired & CTRL.irq_en`, registered.

## Operation
- **Register map (word address):**
  - 0x00 CTRL: bit0 `en`, bit1 `auto_reload`, bit2 `irq_en`; other bits read 0.
  - 0x01 LOAD: 32-bit reload value.
  - 0x02 COUNT: 32-bit current count, read/write.
  - 0x03 STATUS: bit0 `expired`, sticky, write-1-to-clear.
  - 0x04 PRESCALE: bits [15:0]; upper bits read 0.
- **Unmapped addresses:** reads return 0; writes are ignored; `valid` is still asserted.
- **Bus FSM states:**
  - IDLE: `request`=1 latches `we_re`, `address`, `masking`, `w_data`. Next state is WAIT if `WAIT_STATES`>0, else RESP.
  - WAIT: a down-counter is loaded with `WAIT_STATES`-1. The block moves to RESP when it reaches 0.
  - RESP: `valid`=1 and `r_data` is driven. The block returns to IDLE unconditionally.
  - A `request` still high in IDLE after RESP is a new transaction. The requester must deassert `request` in the cycle it sees `valid`.
- **Write commit:** writes take effect on the clock edge leaving RESP, byte-masked. Writing `masking`=0000 changes nothing.
- **Read data:** captured on the edge entering RESP, so it reflects the register state at that edge.
- **Counting:** while `en`=1, the prescale counter `pcnt` increments each cycle. When `pcnt`==PRESCALE, a tick occurs and `pcnt` clears to 0.
- **On each tick:**
  - If COUNT≠0: COUNT decrements by 1.
  - If COUNT==0: `expired` is set. COUNT reloads from LOAD if `auto_reload`; otherwise COUNT stays 0 and `en` clears.
- **Period:** (LOAD+1)·(PRESCALE+1) cycles with auto-reload.
- **Disable:** writing `en`=0 freezes COUNT and clears `pcnt`.
- **Arithmetic:** all arithmetic is unsigned and modulo 2^32. There is no underflow past 0.
- **Simultaneous events:**
  - A bus write to COUNT or CTRL wins over a same-cycle tick update.
  - A hardware set of `expired` wins over a same-cycle W1C.

## Timing
- **Reset values:** `valid`=0, `r_data`=0, `irq`=0. CTRL, LOAD, COUNT, STATUS, PRESCALE and `pcnt` are all 0. The FSM is in IDLE.
- **Latency:** request sampled at edge T → `valid` high during cycle T+1+`WAIT_STATES`.
- **Throughput:** one transaction per `WAIT_STATES`+2 cycles.
- **`irq` latency:** `irq` rises one cycle after `expired` sets and falls one cycle after the W1C commit.
- **Reset mid-transaction:** the transaction is aborted with no `valid`, and nothing is committed.

## Structure
- **Shared package `mmio_timer_pkg`:**
  - Register word-address localparams (`TMR_CTRL`…`TMR_PRESCALE`).
  - CTRL bit indices.
  - Bus FSM state encoding (IDLE/WAIT/RESP).
- **One sub-module, `mmio_timer_core`:** prescaler, COUNT/LOAD datapath and the `expired` logic. Its inputs are a per-register decoded write strobe plus byte-masked data. This leaves the bus FSM and read mux in `mmio_timer`.

## Test plan
- **Reset:** hold `rst`=0 mid-WAIT, then release → `valid` never pulses; all registers read 0; `irq`=0.
- **Read latency:** `WAIT_STATES`=2, write LOAD=0x0000_0005, then read LOAD → `valid` 3 cycles after each request; `r_data`=0x5.
- **Byte-masked write:** write 0xAABBCCDD to LOAD with `masking`=0101 → LOAD reads 0x00BB00DD.
- **Periodic expiry:**
  - Setup: PRESCALE=1, LOAD=3, COUNT=3, CTRL=0b111.
  - Required: `expired` sets every 8 cycles; COUNT reloads to 3.
  - `irq` rises 1 cycle after `expired`.
  - W1C to STATUS drops `irq`.
- **One-shot:** CTRL=0b001, COUNT=2, PRESCALE=0 → `expired` set after 3 cycles; `en` reads 0; COUNT holds 0.
- **Collision and unmapped access:**
  - Write COUNT=0x10 in the same cycle as a tick → COUNT reads 0x10.
  - W1C in the same cycle as expiry → `expired` remains 1.
  - Read address 0x20 → `r_data`=0 with `valid` asserted.
